// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle between the MEM stage and
// the data-memory responder.
interface data_mem_responder_if;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        memwrite;
    logic        memread;
    logic [3:0]  sign_mask;
    logic [31:0] rd_data;
    logic        busy;

    modport master (
        output addr, wr_data, memwrite, memread, sign_mask,
        input  rd_data, busy
    );

    modport slave (
        input  addr, wr_data, memwrite, memread, sign_mask,
        output rd_data, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM responder: formatted sub-word loads,
// read-modify-write sub-word stores, sticky access-error flag.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
    input  logic             clk,
    input  logic             reset_n,
    data_mem_responder_if.slave bus,
    input  logic             err_clr,
    output logic             err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t        r_state;
    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [31:0]   r_word;
    logic [1:0]    r_ld_lane;
    logic          r_ld_word;
    logic          r_ld_half;
    logic          r_ld_signed;
    logic [AW-1:0] r_idx;
    logic [1:0]    r_lane;
    logic          r_half;
    logic [15:0]   r_wdata;
    logic [31:0]   r_old;
    logic          r_busy;
    logic          r_err;

    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic [2:0]    w_size;
    logic          w_in_range;
    logic          w_mask_ok;
    logic          w_align_ok;
    logic          w_req;
    logic          w_bad;
    logic          w_ok;
    logic          w_word_st;
    logic          w_sub_st;
    logic          w_load;
    logic [3:0]    w_be;
    logic [31:0]   w_rep;
    logic [31:0]   w_merged;
    logic          w_we;
    logic [AW-1:0] w_widx;
    logic [31:0]   w_wdat;
    logic [7:0]    w_byte;
    logic [15:0]   w_hw;
    logic [31:0]   w_rd;

    // BASE_ADDR is aligned to the array size, so the offset's upper
    // bits are zero exactly when the address falls inside the array.
    assign w_off      = bus.addr - BASE_ADDR;
    assign w_idx      = w_off[AW+1:2];
    assign w_lane     = w_off[1:0];
    assign w_in_range = (w_off[31:AW+2] == '0);
    assign w_size     = bus.sign_mask[2:0];

    assign w_mask_ok  = (w_size == 3'b001) || (w_size == 3'b011) ||
                        (w_size == 3'b111);
    assign w_align_ok = (w_size == 3'b111) ? (w_lane == 2'b00) :
                        (w_size == 3'b011) ? !w_lane[0] : 1'b1;

    assign w_req     = (r_state == IDLE) && (bus.memread || bus.memwrite);
    assign w_ok      = w_mask_ok && w_align_ok && w_in_range;
    assign w_bad     = w_req && !w_ok;
    assign w_word_st = w_req && w_ok && bus.memwrite && (w_size == 3'b111);
    assign w_sub_st  = w_req && w_ok && bus.memwrite && (w_size != 3'b111);
    assign w_load    = w_req && w_ok && !bus.memwrite;

    assign w_be  = r_half ? (r_lane[1] ? 4'b1100 : 4'b0011)
                          : (4'b0001 << r_lane);
    assign w_rep = r_half ? {2{r_wdata}} : {4{r_wdata[7:0]}};

    always_comb begin
        w_merged = r_old;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) w_merged[8*i +: 8] = w_rep[8*i +: 8];
        end
    end

    // Single write port: word stores at acceptance, merges one cycle
    // later; a reset in the merge cycle suppresses the write.
    assign w_we   = w_word_st || ((r_state == RMW_WR) && reset_n);
    assign w_widx = (r_state == RMW_WR) ? r_idx : w_idx;
    assign w_wdat = (r_state == RMW_WR) ? w_merged : bus.wr_data;

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_widx] <= w_wdat;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_word      <= '0;
            r_ld_lane   <= '0;
            r_ld_word   <= 1'b0;
            r_ld_half   <= 1'b0;
            r_ld_signed <= 1'b0;
            r_idx       <= '0;
            r_lane      <= '0;
            r_half      <= 1'b0;
            r_wdata     <= '0;
            r_old       <= '0;
        end else begin
            if (w_bad)        r_err <= 1'b1;
            else if (err_clr) r_err <= 1'b0;

            unique case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_word      <= r_mem[w_idx];
                        r_ld_lane   <= w_lane;
                        r_ld_word   <= w_size[2];
                        r_ld_half   <= w_size[1];
                        r_ld_signed <= bus.sign_mask[3];
                    end
                    if (w_sub_st) begin
                        r_old   <= r_mem[w_idx];
                        r_idx   <= w_idx;
                        r_lane  <= w_lane;
                        r_half  <= w_size[1];
                        r_wdata <= bus.wr_data[15:0];
                        r_state <= RMW_WR;
                        r_busy  <= 1'b1;
                    end
                end
                RMW_WR: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = r_word[7:0];
        unique case (r_ld_lane)
            2'd0: w_byte = r_word[7:0];
            2'd1: w_byte = r_word[15:8];
            2'd2: w_byte = r_word[23:16];
            2'd3: w_byte = r_word[31:24];
            default: w_byte = r_word[7:0];
        endcase
        w_hw = r_ld_lane[1] ? r_word[31:16] : r_word[15:0];
        if (r_ld_word)
            w_rd = r_word;
        else if (r_ld_half)
            w_rd = {{16{r_ld_signed & w_hw[15]}}, w_hw};
        else
            w_rd = {{24{r_ld_signed & w_byte[7]}}, w_byte};
    end

    assign bus.rd_data = w_rd;
    assign bus.busy    = r_busy;
    assign err         = r_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised bench for data_mem_responder against a byte-level
// behavioural memory model, plus directed scenario checks.
module tb_data_mem_responder;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    logic reset_n;
    logic err_clr;
    logic err;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .err_clr(err_clr),
        .err    (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mm [DEPTH];
    logic [31:0] m_rd = '0;
    bit          m_busy = 1'b0;
    bit          m_err = 1'b0;
    int          p_idx = 0;
    logic [31:0] p_val = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, advance the model, clock, compare.
    task automatic cyc(input bit rst, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input bit clr);
        int sz;
        int idx;
        int off;
        bit bad;
        logic [31:0] w;
        logic [31:0] v;
        reset_n       = rst;
        bus.memread   = rd;
        bus.memwrite  = wr;
        bus.addr      = a;
        bus.wr_data   = d;
        bus.sign_mask = m;
        err_clr       = clr;
        if (!rst) begin
            m_busy = 0;
            m_err  = 0;
            m_rd   = '0;
        end else if (m_busy) begin
            mm[p_idx] = p_val;
            m_busy = 0;
            if (clr) m_err = 0;
        end else if (rd || wr) begin
            case (m[2:0])
                3'b001: sz = 1;
                3'b011: sz = 2;
                3'b111: sz = 4;
                default: sz = 0;
            endcase
            bad = (sz == 0) || (a < BASE) || (a >= BASE + 4 * DEPTH) ||
                  ((a % sz) != 0);
            if (bad) begin
                m_err = 1;
            end else begin
                if (clr) m_err = 0;
                idx = int'((a - BASE) / 4);
                off = int'(a % 4);
                w = mm[idx];
                if (wr) begin
                    for (int k = 0; k < sz; k++)
                        w[8*(off+k) +: 8] = d[8*k +: 8];
                    if (sz == 4) begin
                        mm[idx] = w;
                    end else begin
                        m_busy = 1;
                        p_idx  = idx;
                        p_val  = w;
                    end
                end else begin
                    v = '0;
                    for (int k = 0; k < sz; k++)
                        v[8*k +: 8] = w[8*(off+k) +: 8];
                    if (m[3] && sz < 4 && v[8*sz-1])
                        for (int k = sz; k < 4; k++) v[8*k +: 8] = 8'hFF;
                    m_rd = v;
                end
            end
        end else if (clr) begin
            m_err = 0;
        end
        @(posedge clk);
        #1;
        chk("rd_data", bus.rd_data, m_rd);
        chk("busy", {31'b0, bus.busy}, {31'b0, m_busy});
        chk("err", {31'b0, err}, {31'b0, m_err});
    endtask

    task automatic idle();
        cyc(1, 0, 0, BASE, 0, 4'b0111, 0);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m);
        cyc(1, 0, 1, a, d, m, 0);
    endtask

    task automatic ld(input logic [31:0] a, input logic [3:0] m);
        cyc(1, 1, 0, a, 0, m, 0);
    endtask

    logic [3:0] legal_m [6];
    logic [31:0] ra;
    logic [3:0]  rm;
    int          sel;

    initial begin
        legal_m[0] = 4'b0001; legal_m[1] = 4'b0011; legal_m[2] = 4'b0111;
        legal_m[3] = 4'b1001; legal_m[4] = 4'b1011; legal_m[5] = 4'b1111;

        cyc(0, 0, 0, BASE, 0, 4'b0111, 0);
        cyc(0, 1, 1, BASE, 0, 4'b0111, 1);
        chk("reset_rd", bus.rd_data, 32'h0);
        chk("reset_err", {31'b0, err}, 32'h0);

        for (int i = 0; i < 16; i++)
            st(BASE + 32'(4 * i), $urandom, 4'b0111);

        st(32'h1004, 32'hDEADBEEF, 4'b0111);
        ld(32'h1004, 4'b0111);
        chk("word_ld", bus.rd_data, 32'hDEADBEEF);
        chk("word_busy", {31'b0, bus.busy}, 32'h0);

        st(32'h1008, 32'h80FF7F01, 4'b0111);
        ld(32'h100A, 4'b1001);
        chk("sbyte_ff", bus.rd_data, 32'hFFFFFFFF);
        ld(32'h1009, 4'b0001);
        chk("ubyte_7f", bus.rd_data, 32'h0000007F);
        ld(32'h100B, 4'b1001);
        chk("sbyte_80", bus.rd_data, 32'hFFFFFF80);

        st(32'h100C, 32'h11223344, 4'b0111);
        st(32'h100D, 32'h000000AA, 4'b0001);
        chk("rmw_busy1", {31'b0, bus.busy}, 32'h1);
        ld(32'h100C, 4'b0111);
        chk("rmw_busy0", {31'b0, bus.busy}, 32'h0);
        chk("rmw_ignored", bus.rd_data, 32'hFFFFFF80);
        ld(32'h100C, 4'b0111);
        chk("rmw_word", bus.rd_data, 32'h1122AA44);

        st(32'h1010, 32'h0, 4'b0111);
        st(32'h1012, 32'h0000BEEF, 4'b0011);
        idle();
        ld(32'h1010, 4'b0111);
        chk("hw_word", bus.rd_data, 32'hBEEF0000);
        ld(32'h1012, 4'b1011);
        chk("hw_signed", bus.rd_data, 32'hFFFFBEEF);
        ld(32'h1012, 4'b0011);
        chk("hw_unsigned", bus.rd_data, 32'h0000BEEF);

        ld(32'h1001, 4'b0111);
        chk("err_misal", {31'b0, err}, 32'h1);
        chk("err_rd_hold", bus.rd_data, 32'h0000BEEF);
        cyc(1, 0, 0, BASE, 0, 4'b0111, 1);
        chk("err_clr", {31'b0, err}, 32'h0);
        st(32'h1003, 32'h1234, 4'b0011);
        chk("err_hw_st", {31'b0, err}, 32'h1);
        cyc(1, 0, 0, BASE, 0, 4'b0111, 1);
        ld(32'h0FFC, 4'b0111);
        chk("err_range", {31'b0, err}, 32'h1);
        cyc(1, 1, 0, 32'h1002, 0, 4'b0111, 1);
        chk("err_set_wins", {31'b0, err}, 32'h1);
        cyc(1, 0, 0, BASE, 0, 4'b0111, 1);
        ld(32'h1000, 4'b0111);

        st(32'h1010, 32'h55555555, 4'b0111);
        st(32'h1010, 32'h000000AA, 4'b0001);
        cyc(0, 0, 0, BASE, 0, 4'b0111, 0);
        chk("rst_busy", {31'b0, bus.busy}, 32'h0);
        chk("rst_rd", bus.rd_data, 32'h0);
        ld(32'h1010, 4'b0111);
        chk("rst_abort", bus.rd_data, 32'h55555555);

        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 19));
            if (sel == 0)
                ra = BASE - 32'($urandom_range(1, 8));
            else if (sel == 1)
                ra = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
            else
                ra = BASE + 32'($urandom_range(0, 63));
            rm = ($urandom_range(0, 7) == 0) ? 4'($urandom) :
                 legal_m[$urandom_range(0, 5)];
            cyc($urandom_range(0, 49) != 0, 1'($urandom), 1'($urandom),
                ra, $urandom, rm, $urandom_range(0, 5) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
